// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy flag and flush cancel.
// Define MULDIV_MAC_EN to enable the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU).
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {COMMIT_NONE, COMMIT_SET, COMMIT_ADD, COMMIT_SUB} commit_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    commit_t            pend_kind, issue_kind;
    logic [2*WIDTH-1:0] pend_val, issue_val, product, mul_a, mul_b;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
    logic               is_mul, is_div, is_mac, is_signed, mac_sub;
    logic               issue, commit;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mac    = 1'b0;
        is_signed = 1'b0;
        mac_sub   = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MULDIV_MAC_EN
            OP_MADD:  begin is_mac = 1'b1; is_signed = 1'b1; end
            OP_MADDU: is_mac = 1'b1;
            OP_MSUB:  begin is_mac = 1'b1; is_signed = 1'b1; mac_sub = 1'b1; end
            OP_MSUBU: begin is_mac = 1'b1; mac_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Division works on magnitudes so MIN/-1 and sign rules fall out naturally;
    // a zero divisor is replaced by 1 only to keep the divider defined.
    always_comb begin
        mul_a   = is_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
        mul_b   = is_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
        product = mul_a * mul_b;
        a_mag   = (is_signed && rs[WIDTH-1]) ? -rs : rs;
        b_mag   = (is_signed && rt[WIDTH-1]) ? -rt : rt;
        divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (is_signed && (rs[WIDTH-1] ^ rt[WIDTH-1])) ? -q_mag : q_mag;
        rem     = (is_signed && rs[WIDTH-1]) ? -r_mag : r_mag;
        if (is_div) begin
            issue_val  = {rem, quot};
            issue_kind = (rt == '0) ? COMMIT_NONE : COMMIT_SET;
        end else begin
            issue_val  = product;
            issue_kind = is_mac ? (mac_sub ? COMMIT_SUB : COMMIT_ADD) : COMMIT_SET;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (cancel || count == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        issue  = (state == IDLE) && !cancel && (is_mul || is_div || is_mac);
        commit = (state == RUN) && (count == CW'(1)) && !cancel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           count <= '0;
        else if (issue)         count <= is_div ? DIV_N : MUL_N;
        else if (state == RUN)  count <= cancel ? '0 : count - CW'(1);
    end

    // The accumulate base is the HI/LO value at commit, not at issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi        <= '0;
            lo        <= '0;
            pend_val  <= '0;
            pend_kind <= COMMIT_NONE;
        end else begin
            if (issue) begin
                pend_val  <= issue_val;
                pend_kind <= issue_kind;
            end
            if (commit) begin
                case (pend_kind)
                    COMMIT_SET: {hi, lo} <= pend_val;
`ifdef MULDIV_MAC_EN
                    COMMIT_ADD: {hi, lo} <= {hi, lo} + pend_val;
                    COMMIT_SUB: {hi, lo} <= {hi, lo} - pend_val;
`endif
                    default: ;
                endcase
            end else if (state == IDLE && !cancel && op == OP_MTHI) begin
                hi <= rs;
            end else if (state == IDLE && !cancel && op == OP_MTLO) begin
                lo <= rs;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected busy length and HI/LO,
// a monitor compares them each time busy drops.
module tb_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        cancel;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      run_len = 0;

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .rs(rs), .rt(rt),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one op for exactly one cycle, returning 1ns after the edge that samples it.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        op = o; rs = a; rt = b; cancel = c;
        @(posedge clk);
        #1;
        op = 4'd0; cancel = 1'b0;
    endtask

    task automatic expectResult(input string name, input int cyc, input logic [31:0] h, input logic [31:0] l);
        expect_t e;
        e.name = name; e.cycles = cyc; e.hi = h; e.lo = l;
        sb.push_back(e);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // Monitor: a falling busy marks a completed or aborted op.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                run_len++;
            end else if (run_len > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_busy: got busy run of %0d cycles, required none", run_len);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_cycles"}, 32'(run_len), 32'(e.cycles));
                    checkOutput({e.name, "_hi"}, hi, e.hi);
                    checkOutput({e.name, "_lo"}, lo, e.lo);
                end
                run_len = 0;
            end
        end
    end

    initial begin
        reset_n = 1'b0; op = 4'd0; rs = '0; rt = '0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(posedge clk); #1;

        expectResult("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        waitIdle("mult");
        expectResult("multu", 5, 32'h00000002, 32'hFFFFFFFA);
        applyStimulus(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
        waitIdle("multu");

        expectResult("div", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        waitIdle("div");
        expectResult("divu", 10, 32'h00000001, 32'h7FFFFFFC);
        applyStimulus(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        waitIdle("divu");

        applyStimulus(4'd5, 32'h11, 32'd0, 1'b0);
        applyStimulus(4'd6, 32'h22, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'h11);
        checkOutput("mtlo_lo", lo, 32'h22);
        checkOutput("mtxx_busy", {31'd0, busy}, 32'd0);
        expectResult("div_by_zero", 10, 32'h11, 32'h22);
        applyStimulus(4'd3, 32'd5, 32'd0, 1'b0);
        waitIdle("div_by_zero");
        expectResult("div_min_neg1", 10, 32'h0, 32'h80000000);
        applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        waitIdle("div_min_neg1");

        // Cancel in busy cycle 3, with an MTLO presented in busy cycle 2.
        expectResult("cancel_mid", 3, 32'h0, 32'h80000000);
        applyStimulus(4'd1, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        op = 4'd6; rs = 32'hDEAD;
        @(posedge clk); #1;
        op = 4'd0; cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        waitIdle("cancel_mid");

        applyStimulus(4'd1, 32'd7, 32'd9, 1'b1);
        @(negedge clk);
        checkOutput("cancel_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("cancel_idle_lo", lo, 32'h80000000);

        // Cancel in the final busy cycle must still block the write.
        expectResult("cancel_last", 5, 32'h0, 32'h80000000);
        applyStimulus(4'd1, 32'd7, 32'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        waitIdle("cancel_last");

        // Back-to-back: the second op is presented in the first non-busy cycle.
        expectResult("b2b_first", 5, 32'h0, 32'd6);
        applyStimulus(4'd2, 32'd2, 32'd3, 1'b0);
        waitIdle("b2b_first");
        expectResult("b2b_second", 5, 32'h0, 32'd20);
        applyStimulus(4'd2, 32'd4, 32'd5, 1'b0);
        waitIdle("b2b_second");

        // Asynchronous reset in the middle of a divide.
        expectResult("reset_mid_div", 3, 32'h0, 32'h0);
        applyStimulus(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_hi", hi, 32'd0);
        checkOutput("async_reset_lo", lo, 32'd0);
        #1 reset_n = 1'b1;
        waitIdle("reset_mid_div");
        expectResult("after_reset", 5, 32'h0, 32'd42);
        applyStimulus(4'd1, 32'd6, 32'd7, 1'b0);
        waitIdle("after_reset");

`ifdef MULDIV_MAC_EN
        applyStimulus(4'd5, 32'h0, 32'd0, 1'b0);
        applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        expectResult("maddu", 5, 32'h1, 32'h0);
        applyStimulus(4'd8, 32'd1, 32'd1, 1'b0);
        waitIdle("maddu");
        expectResult("msub", 5, 32'h0, 32'hFFFFFFFF);
        applyStimulus(4'd9, 32'd1, 32'd1, 1'b0);
        waitIdle("msub");
`else
        applyStimulus(4'd8, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        checkOutput("mac_off_busy", {31'd0, busy}, 32'd0);
        checkOutput("mac_off_hi", hi, 32'h0);
        checkOutput("mac_off_lo", lo, 32'd42);
`endif

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s_missing: got no busy completion, required %0d busy cycles", e.name, e.cycles);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
